// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the branch target buffer: 2-bit counter encodings,
// the default index width and the tag width derived from it.
// ---------------------------------------------------------------------------
package btb_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int ENTRY_BITS_DEF = 6;
    localparam int TAG_W_DEF      = 32 - ENTRY_BITS_DEF - 2;

    // Tag covers PC[31:ENTRY_BITS+2]; PC[1:0] is never stored.
    function automatic int tag_width(input int entry_bits);
        return 32 - entry_bits - 2;
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// ---------------------------------------------------------------------------
// btb_sat_ctr
// One 2-bit saturating up/down branch-history counter. Load has priority
// over count; reset value is weakly-not-taken.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   inc_i       saturating increment (stops at ST)
//   dec_i       saturating decrement (stops at SNT)
//   load_i      overwrite counter with load_val_i
//   load_val_i  value used on load
//   ctr_o       current counter value
// ---------------------------------------------------------------------------
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    output logic [1:0] ctr_o
);

    logic [1:0] ctr_q;
    logic [1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = load_val_i;
        end else if (inc_i && (ctr_q != CTR_ST)) begin
            ctr_d = ctr_q + 2'd1;
        end else if (dec_i && (ctr_q != CTR_SNT)) begin
            ctr_d = ctr_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
// Direct-mapped branch target buffer with zero-latency lookup from the fetch
// PC and update from the EX-stage resolved branch. Also keeps saturating
// counts of resolved conditional branches and mispredictions.
//
// Build option
//   BTB_BHT_EN  defined   : each entry carries a 2-bit saturating counter and
//                           p requires counter MSB set.
//               undefined : no counters; a hit predicts taken and a
//                           not-taken hit invalidates the entry.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   PCF           fetch PC to look up
//   p             predict taken for PCF
//   paddr         predicted target (stored target on hit, else PCF+4)
//   BranchTypeE   EX branch type, nonzero = conditional branch
//   BranchE       EX actual outcome, 1 = taken
//   PCE           EX branch PC
//   BranchTarget  EX resolved target
//   PredTakenE    prediction carried down the pipe with this branch
//   StallE        EX stalled, update suppressed
//   BrCount       resolved conditional branches since reset
//   MissCount     mispredicted branches since reset
// ---------------------------------------------------------------------------
module btb_predictor
    import btb_pkg::*;
#(
    parameter int         ENTRY_BITS = ENTRY_BITS_DEF,
    parameter logic [1:0] CTR_INIT   = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        p,
    output logic [31:0] paddr,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTarget,
    input  logic        PredTakenE,
    input  logic        StallE,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
);

    localparam int N     = 1 << ENTRY_BITS;
    localparam int TAG_W = tag_width(ENTRY_BITS);

    logic [ENTRY_BITS-1:0] idx_f;
    logic [ENTRY_BITS-1:0] idx_e;
    logic [TAG_W-1:0]      tag_f;
    logic [TAG_W-1:0]      tag_e;

    logic [N-1:0]          valid_q;
    logic [TAG_W-1:0]      tag_q [N];
    logic [31:0]           tgt_q [N];

    logic                  hit_f;
    logic                  hit_e;
    logic                  upd;
    logic                  alloc;
    logic                  tgt_wr;

    logic [31:0]           br_q;
    logic [31:0]           br_d;
    logic [31:0]           miss_q;
    logic [31:0]           miss_d;

    logic                  unused_pc_lsb;
    assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[ENTRY_BITS+1:2];
    assign tag_f = PCF[31:ENTRY_BITS+2];
    assign idx_e = PCE[ENTRY_BITS+1:2];
    assign tag_e = PCE[31:ENTRY_BITS+2];

    // Lookup reads the registered arrays directly, so a same-cycle update to
    // the same index is only visible from the next cycle.
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign upd    = (BranchTypeE != 3'd0) && !StallE;
    assign alloc  = upd && !hit_e && BranchE;
    // Taken branch always refreshes target; on a hit the tag rewrite is a no-op.
    assign tgt_wr = upd && BranchE;

    assign paddr = hit_f ? tgt_q[idx_f] : (PCF + 32'd4);

`ifdef BTB_BHT_EN
    logic [1:0] ctr_w [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_ctr
        logic sel;
        assign sel = (idx_e == ENTRY_BITS'(gi));

        btb_sat_ctr u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc_i      (upd && hit_e && BranchE && sel),
            .dec_i      (upd && hit_e && !BranchE && sel),
            .load_i     (alloc && sel),
            .load_val_i (CTR_INIT),
            .ctr_o      (ctr_w[gi])
        );
    end

    assign p = hit_f && ctr_w[idx_f][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[idx_e] <= 1'b1;
        end
    end
`else
    logic unused_ctr_init;
    assign unused_ctr_init = ^CTR_INIT;

    assign p = hit_f;

    // Without history, a not-taken hit drops the entry so it stops predicting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[idx_e] <= 1'b1;
        end else if (upd && hit_e && !BranchE) begin
            valid_q[idx_e] <= 1'b0;
        end
    end
`endif

    // Tag/target storage is unreset; valid bits gate any stale contents.
    always_ff @(posedge clk) begin
        if (tgt_wr) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= BranchTarget;
        end
    end

    always_comb begin
        br_d   = br_q;
        miss_d = miss_q;
        if (upd && (br_q != 32'hFFFF_FFFF)) begin
            br_d = br_q + 32'd1;
        end
        if (upd && (PredTakenE != BranchE) && (miss_q != 32'hFFFF_FFFF)) begin
            miss_d = miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            br_q   <= br_d;
            miss_q <= miss_d;
        end
    end

    assign BrCount   = br_q;
    assign MissCount = miss_q;

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

`ifdef BTB_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] PCF;
    logic        p;
    logic [31:0] paddr;
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] PCE;
    logic [31:0] BranchTarget;
    logic        PredTakenE;
    logic        StallE;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    btb_predictor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCF          (PCF),
        .p            (p),
        .paddr        (paddr),
        .BranchTypeE  (BranchTypeE),
        .BranchE      (BranchE),
        .PCE          (PCE),
        .BranchTarget (BranchTarget),
        .PredTakenE   (PredTakenE),
        .StallE       (StallE),
        .BrCount      (BrCount),
        .MissCount    (MissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic [2:0]  btype;
        logic        bre;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic        pred;
        logic        stall;
        logic        exp_p;
        logic [31:0] exp_paddr;
        logic [31:0] exp_br;
        logic [31:0] exp_miss;
    } vec_t;

    typedef struct {
        int          id;
        logic        p;
        logic [31:0] paddr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pcf, input logic [2:0] btype, input logic bre,
                       input logic [31:0] pce, input logic [31:0] tgt, input logic pred,
                       input logic stall, input logic exp_p, input logic [31:0] exp_paddr,
                       input logic [31:0] exp_br, input logic [31:0] exp_miss);
        vec_t v;
        v.pcf = pcf; v.btype = btype; v.bre = bre; v.pce = pce; v.tgt = tgt;
        v.pred = pred; v.stall = stall; v.exp_p = exp_p; v.exp_paddr = exp_paddr;
        v.exp_br = exp_br; v.exp_miss = exp_miss;
        vecs.push_back(v);
    endtask

    task automatic drive_idle(input logic [31:0] pcf);
        PCF = pcf; BranchTypeE = 3'd0; BranchE = 1'b0; PCE = 32'd0;
        BranchTarget = 32'd0; PredTakenE = 1'b0; StallE = 1'b0;
    endtask

    task automatic sample_lookup(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s.p", name), {31'd0, p}, {31'd0, e.p});
            chk($sformatf("%s.paddr", name), paddr, e.paddr);
        end
    endtask

    initial begin
        exp_t e;

        //   pcf      type  BrE pce      tgt      pred stall | p  paddr                         br  miss
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h2000, 1, 0,   0, 32'h1004,                     1,  0);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   1, 32'h2000,                     1,  0);
        add(32'h1000, 3'd1, 0, 32'h1000, 32'h0000, 0, 0,   1, 32'h2000,                     2,  0);
        add(32'h1000, 3'd1, 0, 32'h1000, 32'h0000, 0, 0,   0, BHT ? 32'h2000 : 32'h1004,    3,  0);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   0, BHT ? 32'h2000 : 32'h1004,    3,  0);
        add(32'h1100, 3'd1, 1, 32'h1100, 32'h4000, 1, 0,   0, 32'h1104,                     4,  0);
        add(32'h1100, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   1, 32'h4000,                     4,  0);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   0, 32'h1004,                     4,  0);
        add(32'h1103, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   1, 32'h4000,                     4,  0);
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h2000, 1, 0,   0, 32'h1004,                     5,  0);
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h3000, 1, 0,   1, 32'h2000,                     6,  0);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   1, 32'h3000,                     6,  0);
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h3000, 1, 0,   1, 32'h3000,                     7,  0);
        add(32'h1000, 3'd2, 0, 32'h1000, 32'h3000, 1, 0,   1, 32'h3000,                     8,  1);
        add(32'h1000, 3'd4, 0, 32'h1000, 32'h3000, 1, 1,   BHT, BHT ? 32'h3000 : 32'h1004,  8,  1);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   BHT, BHT ? 32'h3000 : 32'h1004,  8,  1);
        add(32'h2040, 3'd1, 0, 32'h2040, 32'h9000, 0, 0,   0, 32'h2044,                     9,  1);
        add(32'h2040, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   0, 32'h2044,                     9,  1);
        add(32'h1000, 3'd1, 0, 32'h1000, 32'h0000, 1, 0,   BHT, BHT ? 32'h3000 : 32'h1004, 10,  2);
        add(32'h1000, 3'd1, 0, 32'h1000, 32'h0000, 0, 0,   0, BHT ? 32'h3000 : 32'h1004,   11,  2);
        add(32'h1000, 3'd1, 0, 32'h1000, 32'h0000, 0, 0,   0, BHT ? 32'h3000 : 32'h1004,   12,  2);
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h3000, 0, 0,   0, BHT ? 32'h3000 : 32'h1004,   13,  3);
        add(32'h1000, 3'd0, 0, 32'h0000, 32'h0000, 0, 0,   !BHT, 32'h3000,                 13,  3);
        add(32'h1000, 3'd1, 1, 32'h1000, 32'h3000, 1, 0,   !BHT, 32'h3000,                 14,  3);

        rst_n = 1'b0;
        drive_idle(32'h1000);
        #1;
        chk("rst.p", {31'd0, p}, 32'd0);
        chk("rst.paddr", paddr, 32'h1004);
        chk("rst.br", BrCount, 32'd0);
        chk("rst.miss", MissCount, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            PCF          = vecs[i].pcf;
            BranchTypeE  = vecs[i].btype;
            BranchE      = vecs[i].bre;
            PCE          = vecs[i].pce;
            BranchTarget = vecs[i].tgt;
            PredTakenE   = vecs[i].pred;
            StallE       = vecs[i].stall;
            e.id = i; e.p = vecs[i].exp_p; e.paddr = vecs[i].exp_paddr;
            sb.push_back(e);
            #2;
            sample_lookup($sformatf("v%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.br", i), BrCount, vecs[i].exp_br);
            chk($sformatf("v%0d.miss", i), MissCount, vecs[i].exp_miss);
        end

        // Entry 0x1000 now predicts taken to 0x3000 in both builds.
        @(negedge clk);
        drive_idle(32'h1000);
        e.id = 100; e.p = 1'b1; e.paddr = 32'h3000;
        sb.push_back(e);
        #2;
        sample_lookup("pre_rst");

        // Reset asserted while a taken update to a fresh entry is pending.
        PCE = 32'h5000; BranchTypeE = 3'd1; BranchE = 1'b1;
        BranchTarget = 32'h6000; PredTakenE = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst.p", {31'd0, p}, 32'd0);
        chk("async_rst.br", BrCount, 32'd0);
        chk("async_rst.miss", MissCount, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.br", BrCount, 32'd0);
        @(negedge clk);
        drive_idle(32'h5000);
        rst_n = 1'b1;
        e.id = 101; e.p = 1'b0; e.paddr = 32'h5004;
        sb.push_back(e);
        #2;
        sample_lookup("post_rst_5000");
        @(negedge clk);
        PCF = 32'h1000;
        e.id = 102; e.p = 1'b0; e.paddr = 32'h1004;
        sb.push_back(e);
        #2;
        sample_lookup("post_rst_1000");
        @(posedge clk);
        #1;
        chk("post_rst.br", BrCount, 32'd0);
        chk("post_rst.miss", MissCount, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

endmodule
